id_issue_stage: RTL

- Decode/issue stage of the RV32I pipeline, the producer side of the execute-stage ALU interface.
- Takes fetched instructions over a valid/ready handshake and reads source registers from the external register file. Applies writeback bypass and generates immediates.
- Registers the execute fields the ALU consumes: opcode[6:2], func3, func7 bit, operand1, operand2.
- Also inserts load-use bubbles, honours execute backpressure and supports flush.

---
 rtl/rv32i_pkg.sv | 58 +++++
 rtl/rv32i_imm_gen.sv | 27 ++
 rtl/id_issue_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the decode-to-execute payload.
// ID_ILLEGAL_DETECT_EN adds an illegal-instruction flag to the payload.
package rv32i_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned REG_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [OPC_W-1:0] OP_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_IMM    = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_R      = 5'b01100;
  localparam logic [OPC_W-1:0] OP_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OP_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OP_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OP_JAL    = 5'b11011;

  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU    = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR     = 3'b100;
  localparam logic [F3_W-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [F3_W-1:0] F3_OR      = 3'b110;
  localparam logic [F3_W-1:0] F3_AND     = 3'b111;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   func3;
    logic              func7;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] pc;
`ifdef ID_ILLEGAL_DETECT_EN
    logic              illegal;
`endif
  } ex_fields_t;

  // Source-field usage per format; only used fields may raise a load-use hazard.
  function automatic logic reads_rs1(input logic [OPC_W-1:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic reads_rs2(input logic [OPC_W-1:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

  function automatic logic is_known_op(input logic [OPC_W-1:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Sign-extended RV32I immediate, format chosen from the instruction opcode.
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] imm
);

  logic [OPC_W-1:0] opcode;
  logic             unused_len_bits;

  assign opcode          = inst[6:2];
  assign unused_len_bits = ^inst[1:0];

  always_comb begin
    imm = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {inst[31:12], 12'b0};
      OP_JAL:                   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/id_issue_stage.sv
// RV32I decode/issue stage: operand read with writeback bypass, load-use bubbles,
// execute backpressure and flush. ID_ILLEGAL_DETECT_EN adds the ex_illegal output.
module id_issue_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic [RA_W-1:0] rs1_addr,
  output logic [RA_W-1:0] rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [4:0]      ex_opcode,
  output logic [2:0]      ex_func3,
  output logic            ex_func7,
  output logic [XLEN-1:0] ex_operand1,
  output logic [XLEN-1:0] ex_operand2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rd,
`ifdef ID_ILLEGAL_DETECT_EN
  output logic            ex_illegal,
`endif
  output logic [XLEN-1:0] ex_pc
);

  logic [OPC_W-1:0] opcode_c;
  logic [RA_W-1:0]  rd_field_c;
  logic [XLEN-1:0]  imm_c;
  logic [XLEN-1:0]  rs1_val_c;
  logic [XLEN-1:0]  rs2_val_c;
  logic             advance_c;
  logic             hazard_c;
  ex_fields_t       dec_c;
  ex_fields_t       ex_d, ex_q;
  logic             ex_valid_d, ex_valid_q;

  assign opcode_c   = if_inst[6:2];
  assign rd_field_c = if_inst[11:7];
  assign rs1_addr   = if_inst[19:15];
  assign rs2_addr   = if_inst[24:20];

  rv32i_imm_gen u_imm_gen (
    .inst (if_inst),
    .imm  (imm_c)
  );

  // Source operands: x0 is hard zero, then a same-cycle writeback wins over the regfile.
  always_comb begin
    rs1_val_c = rs1_data;
    if (rs1_addr == '0)                      rs1_val_c = '0;
    else if (wb_en && (wb_rd == rs1_addr))   rs1_val_c = wb_data;
    rs2_val_c = rs2_data;
    if (rs2_addr == '0)                      rs2_val_c = '0;
    else if (wb_en && (wb_rd == rs2_addr))   rs2_val_c = wb_data;
  end

  assign advance_c = !ex_valid_q || ex_ready;
  assign hazard_c  = ex_valid_q && (ex_q.opcode == OP_LOAD) && (ex_q.rd != '0) &&
                     ((reads_rs1(opcode_c) && (ex_q.rd == rs1_addr)) ||
                      (reads_rs2(opcode_c) && (ex_q.rd == rs2_addr)));
  assign if_ready  = advance_c && !hazard_c && !flush;

  // Decode the incoming instruction into execute fields.
  always_comb begin
    dec_c        = '0;
    dec_c.opcode = opcode_c;
    dec_c.func3  = if_inst[14:12];
    dec_c.func7  = if_inst[30];
    dec_c.pc     = if_pc;
    dec_c.imm    = imm_c;
    case (opcode_c)
      OP_R: begin
        dec_c.operand1 = rs1_val_c;
        dec_c.operand2 = rs2_val_c;
        dec_c.rd       = rd_field_c;
      end
      OP_IMM, OP_LOAD: begin
        dec_c.operand1 = rs1_val_c;
        dec_c.operand2 = imm_c;
        dec_c.rd       = rd_field_c;
      end
      OP_STORE: begin
        dec_c.operand1   = rs1_val_c;
        dec_c.operand2   = imm_c;
        dec_c.store_data = rs2_val_c;
      end
      OP_BRANCH: begin
        dec_c.operand1 = rs1_val_c;
        dec_c.operand2 = rs2_val_c;
      end
      OP_LUI: begin
        dec_c.operand2 = imm_c;
        dec_c.rd       = rd_field_c;
      end
      OP_AUIPC: begin
        dec_c.operand1 = if_pc;
        dec_c.operand2 = imm_c;
        dec_c.rd       = rd_field_c;
      end
      OP_JAL: begin
        dec_c.operand1 = if_pc;
        dec_c.rd       = rd_field_c;
      end
      OP_JALR: begin
        dec_c.operand1 = if_pc;
        dec_c.operand2 = rs1_val_c;
        dec_c.rd       = rd_field_c;
      end
      default: ;
    endcase
`ifdef ID_ILLEGAL_DETECT_EN
    dec_c.illegal = !is_known_op(opcode_c) || (if_inst[1:0] != 2'b11);
    if (dec_c.illegal) begin
      dec_c.operand1   = '0;
      dec_c.operand2   = '0;
      dec_c.store_data = '0;
      dec_c.rd         = '0;
    end
`endif
  end

  // Flush beats everything; otherwise advance loads an instruction or a bubble.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (advance_c) begin
      if (if_valid && !hazard_c) begin
        ex_valid_d = 1'b1;
        ex_d       = dec_c;
      end else begin
        ex_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_opcode     = ex_q.opcode;
  assign ex_func3      = ex_q.func3;
  assign ex_func7      = ex_q.func7;
  assign ex_operand1   = ex_q.operand1;
  assign ex_operand2   = ex_q.operand2;
  assign ex_store_data = ex_q.store_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rd         = ex_q.rd;
  assign ex_pc         = ex_q.pc;
`ifdef ID_ILLEGAL_DETECT_EN
  assign ex_illegal    = ex_q.illegal;
`endif

endmodule
